// File: rtl/tmds_gearbox_ser.sv
// tmds_gearbox_ser: parametrised N_CH-lane symbol-to-word serializer.
// Each lane holds a BUF_W-bit shift buffer that emits OUT_W bits per cycle
// and is refilled with a whole symbol whenever fewer than OUT_W bits would
// remain. A shared fill counter keeps every lane, including the optional
// clock lane, bit-aligned. IDLE_SYM is loaded whenever no source symbol is
// available, so the serial stream never stalls.
module tmds_gearbox_ser #(
  parameter int              N_CH        = 3,
  parameter int              SYM_W       = 10,
  parameter int              OUT_W       = 2,
  parameter int              MSB_FIRST   = 0,
  parameter int              CLK_LANE    = 1,
  parameter logic [SYM_W-1:0] CLK_PATTERN = 10'b1111100000,
  parameter logic [SYM_W-1:0] IDLE_SYM    = 10'b1101010100,
  parameter int              CNT_W       = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    link_en_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [N_CH*SYM_W-1:0]   s_data_i,
  output logic [N_CH*OUT_W-1:0]   ser_data_o,
  output logic [OUT_W-1:0]        ser_clk_o,
  output logic                    ser_valid_o,
  output logic                    underflow_o,
  output logic [CNT_W-1:0]        underflow_cnt_o,
  input  logic                    clr_cnt_i
);

  localparam int BUF_W = SYM_W + OUT_W - 1;
  localparam int F_W   = $clog2(BUF_W + 1);
  localparam logic [F_W-1:0] OUT_F = F_W'(OUT_W);
  localparam logic [F_W-1:0] SYM_F = F_W'(SYM_W);

  logic [F_W-1:0]   fill;
  logic [F_W-1:0]   rem;
  logic             emit;
  logic             load;
  logic             take_src;
  logic             uf_evt;
  logic [BUF_W-1:0] data_buf [N_CH];
  logic [BUF_W-1:0] clk_buf;
  logic [SYM_W-1:0] sym_sel  [N_CH];

  // Put the first-transmitted bit of a symbol at bit 0.
  function automatic logic [SYM_W-1:0] orient(input logic [SYM_W-1:0] s);
    logic [SYM_W-1:0] o;
    o = s;
    if (MSB_FIRST != 0) begin
      for (int unsigned i = 0; i < SYM_W; i++) begin
        o[i] = s[SYM_W-1-i];
      end
    end
    return o;
  endfunction

  // Shift out the emitted word, then drop a new symbol right above the
  // bits still waiting to be sent.
  function automatic logic [BUF_W-1:0] next_buf(
    input logic [BUF_W-1:0] cur,
    input logic [SYM_W-1:0] sym,
    input logic             do_emit,
    input logic             do_load,
    input logic [F_W-1:0]   pos
  );
    logic [BUF_W-1:0] b;
    logic [BUF_W-1:0] keep;
    b = do_emit ? (cur >> OUT_W) : cur;
    if (do_load) begin
      keep = (BUF_W'(1) << pos) - BUF_W'(1);
      b    = (b & keep) | (BUF_W'(sym) << pos);
    end
    return b;
  endfunction

  // Emit/load decision from the registered fill level and source selection.
  always_comb begin
    emit     = (fill >= OUT_F);
    rem      = emit ? (fill - OUT_F) : fill;
    load     = (rem < OUT_F);
    take_src = link_en_i & s_valid_i;
    uf_evt   = load & link_en_i & ~s_valid_i;
    for (int unsigned c = 0; c < N_CH; c++) begin
      sym_sel[c] = orient(take_src ? s_data_i[c*SYM_W +: SYM_W] : IDLE_SYM);
    end
  end

  // Ready is masked by reset so it reads 0 while the block is held in reset.
  assign s_ready_o = load & link_en_i & rst_n_i;

  // Fill counter, lane buffers and registered serial outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fill        <= '0;
      clk_buf     <= '0;
      ser_data_o  <= '0;
      ser_clk_o   <= '0;
      ser_valid_o <= 1'b0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        data_buf[c] <= '0;
      end
    end else begin
      fill        <= load ? (rem + SYM_F) : rem;
      ser_valid_o <= emit;
      for (int unsigned c = 0; c < N_CH; c++) begin
        data_buf[c] <= next_buf(data_buf[c], sym_sel[c], emit, load, rem);
        if (emit) begin
          ser_data_o[c*OUT_W +: OUT_W] <= data_buf[c][OUT_W-1:0];
        end
      end
      clk_buf <= next_buf(clk_buf, CLK_PATTERN, emit, load, rem);
      if (emit) begin
        ser_clk_o <= (CLK_LANE != 0) ? clk_buf[OUT_W-1:0] : '0;
      end
    end
  end

  // Underflow pulse and saturating counter; a clear beats a same-cycle event.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      underflow_o     <= 1'b0;
      underflow_cnt_o <= '0;
    end else begin
      underflow_o <= uf_evt;
      if (clr_cnt_i) begin
        underflow_cnt_o <= '0;
      end else if (uf_evt && (underflow_cnt_o != '1)) begin
        underflow_cnt_o <= underflow_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tmds_gearbox_ser.sv
// Bench for tmds_gearbox_ser: two instances (default LSB-first OUT_W=2, and
// MSB-first OUT_W=4 with a 2-bit counter) compared against a bit-queue model.
module tb_tmds_gearbox_ser;

  localparam logic [9:0] IDLE = 10'b1101010100;
  localparam logic [9:0] CLKP = 10'b1111100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, link_en, va, vb, clra, clrb;
  logic [29:0] da, db;
  logic        sr_a, sr_b, val_a, val_b, uf_a, uf_b;
  logic [5:0]  ser_a;
  logic [11:0] ser_b;
  logic [1:0]  sclk_a;
  logic [3:0]  sclk_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  tmds_gearbox_ser #(.N_CH(3), .SYM_W(10), .OUT_W(2), .MSB_FIRST(0), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .link_en_i(link_en), .s_valid_i(va),
    .s_ready_o(sr_a), .s_data_i(da), .ser_data_o(ser_a), .ser_clk_o(sclk_a),
    .ser_valid_o(val_a), .underflow_o(uf_a), .underflow_cnt_o(cnt_a), .clr_cnt_i(clra));

  tmds_gearbox_ser #(.N_CH(3), .SYM_W(10), .OUT_W(4), .MSB_FIRST(1), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .link_en_i(link_en), .s_valid_i(vb),
    .s_ready_o(sr_b), .s_data_i(db), .ser_data_o(ser_b), .ser_clk_o(sclk_b),
    .ser_valid_o(val_b), .underflow_o(uf_b), .underflow_cnt_o(cnt_b), .clr_cnt_i(clrb));

  int errors = 0;
  int checks = 0;

  // Model: per instance, a queue of time-ordered bits {clk, ch2, ch1, ch0}.
  logic [3:0]  q [2][$];
  logic [11:0] e_data  [2];
  logic [3:0]  e_clk   [2];
  logic        e_valid [2];
  logic        e_uf    [2];
  int          e_cnt   [2];
  logic [9:0]  ramp;

  function automatic int ow(int d);   return (d == 0) ? 2 : 4;     endfunction
  function automatic int cmax(int d); return (d == 0) ? 65535 : 3; endfunction

  function automatic logic m_ready(int d);
    int n, r;
    n = q[d].size();
    r = (n >= ow(d)) ? n - ow(d) : n;
    return rst_n && link_en && (r < ow(d));
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      e_data[d] = '0; e_clk[d] = '0; e_valid[d] = 1'b0; e_uf[d] = 1'b0; e_cnt[d] = 0;
    end
  endtask

  task automatic m_step(int d, logic v, logic [29:0] dat, logic clr);
    int w, n;
    logic emit, ld, uf;
    logic [3:0] e;
    logic [9:0] sym;
    w    = ow(d);
    n    = q[d].size();
    emit = (n >= w);
    ld   = ((n - (emit ? w : 0)) < w);
    if (emit) begin
      for (int j = 0; j < w; j++) begin
        e = q[d].pop_front();
        for (int c = 0; c < 3; c++) e_data[d][c*w+j] = e[c];
        e_clk[d][j] = e[3];
      end
    end
    e_valid[d] = emit;
    uf = ld && link_en && !v;
    e_uf[d] = uf;
    if (clr) e_cnt[d] = 0;
    else if (uf && e_cnt[d] < cmax(d)) e_cnt[d]++;
    if (ld) begin
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < 3; c++) begin
          sym  = (link_en && v) ? dat[c*10 +: 10] : IDLE;
          e[c] = (d == 1) ? sym[9-k] : sym[k];
        end
        e[3] = CLKP[k];
        q[d].push_back(e);
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("data_a", 32'(ser_a), 32'(e_data[0][5:0]));
    chk("clk_a", 32'(sclk_a), 32'(e_clk[0][1:0]));
    chk("valid_a", 32'(val_a), 32'(e_valid[0]));
    chk("uf_a", 32'(uf_a), 32'(e_uf[0]));
    chk("cnt_a", 32'(cnt_a), 32'(e_cnt[0]));
    chk("data_b", 32'(ser_b), 32'(e_data[1]));
    chk("clk_b", 32'(sclk_b), 32'(e_clk[1]));
    chk("valid_b", 32'(val_b), 32'(e_valid[1]));
    chk("uf_b", 32'(uf_b), 32'(e_uf[1]));
    chk("cnt_b", 32'(cnt_b), 32'(e_cnt[1]));
  endtask

  // One clock: check ready, advance model on the edge, check registered outputs.
  task automatic tick();
    logic acc_a;
    #1;
    chk("ready_a", 32'(sr_a), 32'(m_ready(0)));
    chk("ready_b", 32'(sr_b), 32'(m_ready(1)));
    acc_a = m_ready(0) && va;
    @(posedge clk);
    if (rst_n) begin
      m_step(0, va, da, clra);
      m_step(1, vb, db, clrb);
    end else begin
      m_reset();
    end
    #1;
    check_outputs();
    if (acc_a) ramp = ramp + 10'd1;
    da = {~ramp, ramp ^ 10'h155, ramp};
  endtask

  initial begin
    logic done;
    rst_n = 1'b0; link_en = 1'b1; va = 1'b1; vb = 1'b1; clra = 1'b0; clrb = 1'b0;
    ramp = 10'd1;
    da = {~ramp, ramp ^ 10'h155, ramp};
    db = 30'($urandom);
    m_reset();
    repeat (3) tick();
    rst_n = 1'b1;

    // Continuous valid: ramp on A, random on B.
    for (int i = 0; i < 40; i++) begin
      db = 30'($urandom);
      tick();
    end

    // Single starved load slot on A.
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      va   = m_ready(0) ? 1'b0 : 1'b1;
      done = !va;
      tick();
    end
    va = 1'b1;
    repeat (6) tick();
    chk("starve_cnt_a", 32'(cnt_a), 32'd1);

    // Link disabled for 20 cycles, then re-enabled.
    link_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      db = 30'($urandom);
      tick();
    end
    chk("disabled_cnt_a", 32'(cnt_a), 32'd1);
    link_en = 1'b1;
    repeat (12) tick();

    // Randomly gapped valid on both instances.
    for (int i = 0; i < 80; i++) begin
      va = ($urandom_range(0, 3) != 0);
      vb = ($urandom_range(0, 3) != 0);
      db = 30'($urandom);
      tick();
    end
    va = 1'b1;

    // Saturate the 2-bit counter on B, then clear it on an underflow cycle.
    vb = 1'b0;
    repeat (30) tick();
    chk("cnt_b_sat", 32'(cnt_b), 32'd3);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      clrb = m_ready(1);
      tick();
      if (clrb) done = 1'b1;
      clrb = 1'b0;
    end
    chk("clr_slot_found", 32'(done), 32'd1);
    chk("cnt_b_clr_wins", 32'(cnt_b), 32'd0);
    vb = 1'b1;
    repeat (7) tick();

    // Asynchronous reset between edges, mid-symbol.
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_ready_a", 32'(sr_a), 32'd0);
    chk("rst_ready_b", 32'(sr_b), 32'd0);
    check_outputs();
    repeat (2) tick();
    rst_n = 1'b1;
    db = {3{10'h200}};
    tick();
    chk("valid_a_one_edge", 32'(val_a), 32'd0);
    db = 30'($urandom);
    tick();
    chk("valid_a_two_edges", 32'(val_a), 32'd1);
    chk("msb_first_word", 32'(ser_b[3:0]), 32'h1);

    for (int i = 0; i < 60; i++) begin
      va = ($urandom_range(0, 4) != 0);
      vb = ($urandom_range(0, 4) != 0);
      db = 30'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
